// File: rtl/ram_reader_if.sv
// Bus bundle for ram_reader: burst request, shared RAM read port and the
// streaming output. The master side is the reader itself.
interface ram_reader_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          Start;
    logic [AW-1:0] FirstAddr;
    logic [AW-1:0] LastAddr;
    logic          Grant;
    logic [AW-1:0] RamAddr;
    logic          RamRd;
    logic [DW-1:0] RamQ;
    logic [DW-1:0] OutData;
    logic          OutValid;
    logic          OutReady;
    logic          Busy;
    logic          Done;

    modport master (
        input  Start, FirstAddr, LastAddr, Grant, RamQ, OutReady,
        output RamAddr, RamRd, OutData, OutValid, Busy, Done
    );

    modport slave (
        output Start, FirstAddr, LastAddr, Grant, RamQ, OutReady,
        input  RamAddr, RamRd, OutData, OutValid, Busy, Done
    );
endinterface

// File: rtl/ram_reader.sv
// Streams a contiguous (wrapping) address range out of a shared RAM port
// through a 2-entry FIFO, respecting the writer's Grant and the sink's ready.
module ram_reader #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic         Clock,
    input  logic         Resetn,
    ram_reader_if.master bus
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   left_q, left_d;     // reads still to issue
    logic          inflight_q;         // a read was issued last cycle
    logic [DW-1:0] fifo_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    count_q, count_d;

    logic          pop, push, issue;
    logic [1:0]    count_after_pop;
    logic [AW-1:0] span;

    assign push            = inflight_q;
    assign pop             = bus.OutValid & bus.OutReady;
    assign count_after_pop = count_q - {1'b0, pop};
    assign span            = bus.LastAddr - bus.FirstAddr;

    // Occupancy is judged after this cycle's pop so a steady 1 byte/cycle
    // stream can keep one entry buffered and one read in flight.
    assign issue = (state_q == StRead) && bus.Grant && (left_q != '0) &&
                   ((count_after_pop + {1'b0, inflight_q}) < 2'd2);

    // FIFO occupancy bookkeeping.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next state, read address and remaining-read counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StRead;
                    addr_d  = bus.FirstAddr;
                    left_d  = {1'b0, span} + (AW+1)'(1);
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    left_d = left_q - (AW+1)'(1);
                    if (left_q == (AW+1)'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Nothing is issued here, so count_d covers the in-flight read too.
                if (count_d == 2'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            inflight_q <= issue;
        end
    end

    // FIFO storage: capture RamQ one cycle after each read strobe.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.RamQ;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end

    // Outputs; OutData is forced to zero while the FIFO is empty.
    always_comb begin
        bus.RamRd    = issue;
        bus.RamAddr  = addr_q;
        bus.OutValid = (count_q != 2'd0);
        bus.OutData  = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
        bus.Busy     = (state_q != StIdle);
        bus.Done     = (state_q == StDone);
    end

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader with a burst-level reference model.
module tb_ram_reader;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int NW = 1 << AW;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    always #5 Clock = ~Clock;

    ram_reader_if #(.AW(AW), .DW(DW)) bus ();
    ram_reader #(.AW(AW), .DW(DW)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));

    logic [DW-1:0] mem [NW];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state
    logic [DW-1:0] exp_q [$];
    bit            active = 1'b0;
    logic [AW-1:0] next_addr = '0;
    int            reads_left = 0;
    bit            emptied_last = 1'b0;
    int            start_cyc = 0;
    bit            first_seen = 1'b0;
    bit            hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit            reset_prev = 1'b0;

    // Observation logs (appended only by the compare process)
    logic [DW-1:0] got [$];
    int            acc_cyc [$];
    int            done_cnt = 0;
    int            done_cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM model: registered read, data valid the cycle after RamRd.
    always @(posedge Clock) begin
        if (bus.RamRd) bus.RamQ <= mem[bus.RamAddr];
    end

    // Compare process: every cycle, sampled mid-cycle.
    always @(negedge Clock) begin
        cyc++;
        if (reset_prev) begin
            check("reset_outputs", int'({bus.RamRd, bus.OutValid, bus.Busy, bus.Done,
                                         bus.RamAddr, bus.OutData}), 0);
        end
        if (hold_prev) begin
            check("hold_valid", int'(bus.OutValid), 1);
            check("hold_data", int'(bus.OutData), int'(prev_data));
        end
        if (!bus.Grant) check("ramrd_without_grant", int'(bus.RamRd), 0);
        if (!active) check("idle_outputs", int'({bus.OutValid, bus.RamRd}), 0);
        check("busy", int'(bus.Busy), int'(active));
        check("done", int'(bus.Done), int'(active && exp_q.size() == 0 && emptied_last));
        emptied_last = 1'b0;

        if (bus.RamRd) begin
            check("rd_addr", int'(bus.RamAddr), int'(next_addr));
            check("rd_extra", int'(reads_left > 0), 1);
            next_addr = next_addr + AW'(1);
            reads_left--;
        end

        if (bus.OutValid && bus.OutReady) begin
            if (exp_q.size() == 0) check("extra_byte", 1, 0);
            else check("data", int'(bus.OutData), int'(exp_q.pop_front()));
            got.push_back(bus.OutData);
            acc_cyc.push_back(cyc);
            if (!first_seen) begin
                check("latency_ge3", int'(cyc - start_cyc >= 3), 1);
                first_seen = 1'b1;
            end
            if (exp_q.size() == 0) emptied_last = 1'b1;
        end

        // Start is only honoured while idle (including not in the Done cycle).
        if (Resetn && bus.Start && !active) begin
            int len;
            len = ((int'(bus.LastAddr) - int'(bus.FirstAddr)) % NW + NW) % NW + 1;
            for (int k = 0; k < len; k++) exp_q.push_back(mem[(int'(bus.FirstAddr) + k) % NW]);
            next_addr  = bus.FirstAddr;
            reads_left = len;
            start_cyc  = cyc;
            first_seen = 1'b0;
            active     = 1'b1;
        end

        if (bus.Done) begin
            done_cnt++;
            done_cyc = cyc;
            active   = 1'b0;
        end

        hold_prev = bus.OutValid && !bus.OutReady && Resetn;
        prev_data = bus.OutData;

        if (!Resetn) begin
            active       = 1'b0;
            exp_q.delete();
            reads_left   = 0;
            emptied_last = 1'b0;
            reset_prev   = 1'b1;
        end else begin
            reset_prev = 1'b0;
        end
    end

    // mode 0: ready/grant high; 1: random ready + 5-cycle grant gap; 2: stray Start mid-burst
    task automatic run_burst(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                             input int exp_len, output int base);
        int d0;
        int k;
        d0   = done_cnt;
        base = got.size();
        bus.FirstAddr = f;
        bus.LastAddr  = l;
        bus.Start     = 1'b1;
        @(posedge Clock); #1;
        bus.Start     = 1'b0;
        bus.FirstAddr = '0;
        bus.LastAddr  = '0;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            if (mode == 1) begin
                bus.OutReady = 1'($urandom_range(0, 1));
                bus.Grant    = !(k >= 10 && k < 15);
            end
            if (mode == 2 && k == 3) begin
                bus.Start     = 1'b1;
                bus.FirstAddr = AW'(0);
                bus.LastAddr  = AW'(20);
            end else begin
                bus.Start = 1'b0;
            end
            @(posedge Clock); #1;
            k++;
        end
        bus.Start    = 1'b0;
        bus.OutReady = 1'b1;
        bus.Grant    = 1'b1;
        check("burst_timeout", int'(done_cnt == d0), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("byte_count", got.size() - base, exp_len);
        @(posedge Clock); #1;
    endtask

    task automatic pin(input string name, input int base, input int idx, input int exp);
        check(name, (got.size() > base + idx) ? int'(got[base + idx]) : -1, exp);
    endtask

    initial begin
        int b;
        for (int i = 0; i < NW; i++) mem[i] = DW'(i * 3 + 1);
        bus.Start     = 1'b0;
        bus.FirstAddr = '0;
        bus.LastAddr  = '0;
        bus.Grant     = 1'b1;
        bus.OutReady  = 1'b1;
        Resetn        = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;
        @(posedge Clock); #1;

        // 3..6 at full rate: 10,13,16,19 back to back, Done right after
        run_burst(AW'(3), AW'(6), 0, 4, b);
        pin("t1_b0", b, 0, 10);
        pin("t1_b1", b, 1, 13);
        pin("t1_b2", b, 2, 16);
        pin("t1_b3", b, 3, 19);
        check("t1_consecutive", (acc_cyc.size() >= b + 4) ? acc_cyc[b + 3] - acc_cyc[b] : -1, 3);
        check("t1_done_timing", (acc_cyc.size() >= b + 4) ? done_cyc - acc_cyc[b + 3] : -1, 1);

        // Wrapping range 30..1
        run_burst(AW'(30), AW'(1), 0, 4, b);
        pin("t2_b0", b, 0, 91);
        pin("t2_b1", b, 1, 94);
        pin("t2_b2", b, 2, 1);
        pin("t2_b3", b, 3, 4);

        // Single byte
        run_burst(AW'(9), AW'(9), 0, 1, b);
        pin("t3_b0", b, 0, 28);

        // Full range with random backpressure and a grant gap
        run_burst(AW'(0), AW'(31), 1, 32, b);
        pin("t4_first", b, 0, 1);
        pin("t4_last", b, 31, 94);

        // Stray Start mid-burst must not alter the burst
        run_burst(AW'(10), AW'(20), 2, 11, b);
        pin("t5_first", b, 0, 31);
        pin("t5_last", b, 10, 61);

        // Reset mid-burst, then a fresh burst
        begin
            int d0;
            bus.FirstAddr = AW'(0);
            bus.LastAddr  = AW'(31);
            bus.Start     = 1'b1;
            @(posedge Clock); #1;
            bus.Start = 1'b0;
            repeat (8) @(posedge Clock);
            #1 Resetn = 1'b0;
            d0 = done_cnt;
            @(posedge Clock); #1;
            Resetn = 1'b1;
            repeat (5) @(posedge Clock);
            #1;
            check("no_done_after_reset", done_cnt - d0, 0);
        end
        run_burst(AW'(3), AW'(6), 0, 4, b);
        pin("t6_b0", b, 0, 10);
        pin("t6_b3", b, 3, 19);

        repeat (2) @(posedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter AW, default 5, RAM address width.
REQ-002 SHALL have parameter DW, default 8, RAM data width.
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 Resetn  input  1  reset, synchronous, active-low.
REQ-005 Start  input  1  one-cycle request to begin a read-out burst.
REQ-006 FirstAddr  input  AW  first address of burst, sampled when Start is accepted.
REQ-007 LastAddr  input  AW  last address of burst, sampled when Start is accepted.
REQ-008 Grant  input  1  1 = reader may use RAM port; 0 = writer owns port.
REQ-009 RamAddr  output  AW  RAM read address.
REQ-010 RamRd  output  1  read strobe; RamQ valid exactly 1 cycle later.
REQ-011 RamQ  input  DW  RAM read data.
REQ-012 OutData  output  DW  streamed byte.
REQ-013 OutValid  output  1  OutData valid.
REQ-014 OutReady  input  1  sink accepts OutData when OutValid&OutReady.
REQ-015 Busy  output  1  burst in progress.
REQ-016 Done  output  1  one-cycle pulse after last byte is accepted.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN, DONE.
REQ-018 IDLE: Start=1 SHALL latch FirstAddr/LastAddr, set Busy, enter READ next cycle; Start in any other state SHALL be ignored.
REQ-019 Burst length SHALL be ((LastAddr - FirstAddr) mod 2^AW) + 1; FirstAddr==LastAddr gives 1 byte; LastAddr<FirstAddr wraps 2^AW-1 -> 0.
REQ-020 Read address counter SHALL start at FirstAddr and increment modulo 2^AW after each issued read.
REQ-021 READ: RamRd SHALL assert only when Grant=1 and (buffer occupancy + reads in flight) < 2, and reads remain.
REQ-022 RamAddr SHALL be valid in the same cycle as RamRd; RamRd=0 whenever Grant=0.
REQ-023 RamQ SHALL be captured into a 2-entry FIFO the cycle after each RamRd; no byte dropped or duplicated under any OutReady/Grant pattern.
REQ-024 OutData/OutValid SHALL come from the FIFO head; once OutValid=1, OutData SHALL hold until accepted.
REQ-025 Simultaneous capture and acceptance SHALL leave occupancy unchanged.
REQ-026 Last read issued SHALL move FSM READ -> DRAIN.
REQ-027 DRAIN SHALL wait until FIFO empty and nothing in flight, then enter DONE.
REQ-028 DONE SHALL pulse Done=1 for one cycle, clear Busy, return to IDLE; Start in DONE cycle ignored.
REQ-029 Bytes SHALL emerge in address order; max throughput 1 byte/cycle with OutReady=1, Grant=1.
REQ-030 First OutValid SHALL occur no earlier than 3 cycles after Start accepted (READ entry, RamRd, capture).

Reset
REQ-031 Resetn=0 at a rising edge SHALL force IDLE, empty FIFO, discard in-flight read, and drive RamRd=0, OutValid=0, Busy=0, Done=0, RamAddr=0, OutData=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no Done pulse; next Start after release SHALL behave as from power-up.

Verification
REQ-033 First=3, Last=6, OutReady=1, Grant=1 -> bytes mem[3..6] on 4 consecutive cycles, Done one cycle after last accept, Busy low after.
REQ-034 First=30, Last=1 -> 4 bytes mem[30],mem[31],mem[0],mem[1] in order, RamAddr wraps 31 -> 0.
REQ-035 First=Last=9 -> exactly one byte mem[9], one Done pulse.
REQ-036 First=0, Last=31, OutReady toggled randomly, Grant low 5 cycles mid-burst -> 32 bytes in order, no loss/duplication, RamRd never high while Grant=0, OutData stable while stalled.
REQ-037 Start during burst -> ignored, burst count unchanged; Resetn=0 mid-burst -> outputs zero next cycle, no Done, fresh Start then completes normally.
